// File: rtl/alu_32bit_pkg.sv
// rtl/alu_32bit_pkg.sv - opcodes, float field constants and shared leading-zero count for alu_32bit
package alu_32bit_pkg;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_SUB    = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SLL    = 5'b00101;
  localparam logic [4:0] OP_SRL    = 5'b00110;
  localparam logic [4:0] OP_SLTU   = 5'b00111;
  localparam logic [4:0] OP_SLT    = 5'b01000;
  localparam logic [4:0] OP_SGE    = 5'b01001;
  localparam logic [4:0] OP_SRA    = 5'b01010;
  localparam logic [4:0] OP_SEQ    = 5'b01011;
  localparam logic [4:0] OP_SNE    = 5'b01100;
  localparam logic [4:0] OP_ADDF   = 5'b01111;
  localparam logic [4:0] OP_CVTITF = 5'b11110;
  localparam logic [4:0] OP_CVTFTI = 5'b11111;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

  // Number of zeros above the most significant one; 32 for an all-zero word.
  function automatic logic [5:0] lzc32(input logic [31:0] x);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/alu_32bit_fp_add32.sv
// rtl/alu_32bit_fp_add32.sv - combinational single-precision adder, truncating, denormals flushed
module alu_32bit_fp_add32
  import alu_32bit_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_overflow
);

  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [23:0] w_ma;
  logic [23:0] w_mb;
  logic        w_a_big;
  logic        w_sign_big;
  logic        w_same_sign;
  logic [7:0]  w_e_big;
  logic [7:0]  w_e_small;
  logic [23:0] w_m_big;
  logic [23:0] w_m_small;
  logic [7:0]  w_diff;
  logic [23:0] w_m_aligned;
  logic [24:0] w_sum;
  logic [5:0]  w_lz;

  assign w_ea = i_a[30:23];
  assign w_eb = i_b[30:23];
  // Exponent zero means zero or denormal; both contribute no significand.
  assign w_ma = (w_ea == 8'd0) ? 24'd0 : {1'b1, i_a[22:0]};
  assign w_mb = (w_eb == 8'd0) ? 24'd0 : {1'b1, i_b[22:0]};

  // Ordering by magnitude keeps the significand difference non-negative.
  assign w_a_big     = (i_a[30:0] >= i_b[30:0]);
  assign w_sign_big  = w_a_big ? i_a[31] : i_b[31];
  assign w_same_sign = (i_a[31] == i_b[31]);
  assign w_e_big     = w_a_big ? w_ea : w_eb;
  assign w_e_small   = w_a_big ? w_eb : w_ea;
  assign w_m_big     = w_a_big ? w_ma : w_mb;
  assign w_m_small   = w_a_big ? w_mb : w_ma;
  assign w_diff      = w_e_big - w_e_small;
  assign w_m_aligned = (w_diff > 8'd23) ? 24'd0 : (w_m_small >> w_diff);
  assign w_sum       = w_same_sign ? ({1'b0, w_m_big} + {1'b0, w_m_aligned})
                                   : ({1'b0, w_m_big} - {1'b0, w_m_aligned});
  assign w_lz        = lzc32({7'd0, w_sum});

  // Normalise the raw sum and classify NaN/inf/zero/underflow outcomes.
  always_comb begin
    logic [9:0]  v_exp;
    logic [24:0] v_norm;
    o_result   = 32'd0;
    o_overflow = 1'b0;
    v_exp      = 10'd0;
    v_norm     = 25'd0;
    if (w_ea == 8'hFF || w_eb == 8'hFF) begin
      o_result   = FP_QNAN;
      o_overflow = 1'b1;
    end else if (w_sum != 25'd0) begin
      if (w_sum[24]) begin
        v_norm = w_sum >> 1;
        v_exp  = {2'b00, w_e_big} + 10'd1;
      end else begin
        v_norm = w_sum << (w_lz - 6'd8);
        v_exp  = {2'b00, w_e_big} - {4'd0, w_lz - 6'd8};
      end
      if ($signed(v_exp) >= 10'sd255) begin
        o_result   = FP_POS_INF | {w_sign_big, 31'd0};
        o_overflow = 1'b1;
      end else if ($signed(v_exp) > 10'sd0) begin
        o_result = {w_sign_big, v_exp[7:0], 23'(v_norm)};
      end
    end
  end

endmodule

// File: rtl/alu_32bit.sv
// rtl/alu_32bit.sv - registered 32-bit integer/float ALU for the DLX execute stage
module alu_32bit
  import alu_32bit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Op,
  output logic [31:0] Result,
  output logic        Carryout,
  output logic        Overflow,
  output logic        Zero,
  output logic        Set
);

  logic [31:0] r_result;
  logic        r_carry;
  logic        r_ovf;
  logic        r_zero;
  logic        r_set;

  logic        w_is_sub;
  logic [31:0] w_b_eff;
  logic [32:0] w_sum;
  logic        w_add_ovf;
  logic [31:0] w_fadd_result;
  logic        w_fadd_ovf;
  logic [31:0] w_itf_mag;
  logic [5:0]  w_itf_lz;
  logic [31:0] w_itf_norm;
  logic [7:0]  w_itf_exp;
  logic [31:0] w_itf_result;
  logic [7:0]  w_fti_ue;
  logic [31:0] w_fti_mant;
  logic [31:0] w_fti_mag;
  logic [31:0] w_fti_sat;
  logic [31:0] w_fti_result;
  logic        w_fti_ovf;
  logic [31:0] w_result;
  logic        w_carry;
  logic        w_ovf;
  logic        w_set;

  // SUB reuses the adder as A + ~B + 1.
  assign w_is_sub  = (Op == OP_SUB);
  assign w_b_eff   = w_is_sub ? ~B : B;
  assign w_sum     = {1'b0, A} + {1'b0, w_b_eff} + 33'(w_is_sub);
  assign w_add_ovf = (A[31] == w_b_eff[31]) && (w_sum[31] != A[31]);

  alu_32bit_fp_add32 u_fp_add (
    .i_a        (A),
    .i_b        (B),
    .o_result   (w_fadd_result),
    .o_overflow (w_fadd_ovf)
  );

  // Int to float: sign-magnitude, left-justify the leading one, drop bits below the mantissa.
  assign w_itf_mag    = A[31] ? (~A + 32'd1) : A;
  assign w_itf_lz     = lzc32(w_itf_mag);
  assign w_itf_norm   = w_itf_mag << w_itf_lz;
  assign w_itf_exp    = 8'(FP_BIAS + 31) - {2'b00, w_itf_lz};
  assign w_itf_result = (A == 32'd0) ? 32'd0 : {A[31], w_itf_exp, 23'(w_itf_norm >> 8)};

  // Float to int: place the significand by the unbiased exponent, truncating toward zero.
  assign w_fti_ue   = A[30:23] - 8'(FP_BIAS);
  assign w_fti_mant = {8'd0, 1'b1, A[22:0]};
  assign w_fti_mag  = (w_fti_ue >= 8'd23) ? (w_fti_mant << (w_fti_ue - 8'd23))
                                          : (w_fti_mant >> (8'd23 - w_fti_ue));
  assign w_fti_sat  = A[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;

  // Float to int range handling: NaN/inf and large magnitudes saturate, -2^31 is exact.
  always_comb begin
    w_fti_result = 32'd0;
    w_fti_ovf    = 1'b0;
    if (A[30:23] == 8'hFF) begin
      w_fti_result = w_fti_sat;
      w_fti_ovf    = 1'b1;
    end else if (A[30:23] < 8'(FP_BIAS)) begin
      w_fti_result = 32'd0;
    end else if (w_fti_ue >= 8'd31) begin
      if (A[31] && w_fti_ue == 8'd31 && A[22:0] == 23'd0) begin
        w_fti_result = 32'h8000_0000;
      end else begin
        w_fti_result = w_fti_sat;
        w_fti_ovf    = 1'b1;
      end
    end else begin
      w_fti_result = A[31] ? (~w_fti_mag + 32'd1) : w_fti_mag;
    end
  end

  // Opcode mux; compares put their outcome in both Result[0] and Set.
  always_comb begin
    w_result = 32'd0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    w_set    = 1'b0;
    case (Op)
      OP_AND:    w_result = A & B;
      OP_OR:     w_result = A | B;
      OP_XOR:    w_result = A ^ B;
      OP_ADD, OP_SUB: begin
        w_result = w_sum[31:0];
        w_carry  = w_sum[32];
        w_ovf    = w_add_ovf;
      end
      OP_SLL:    w_result = A << B[4:0];
      OP_SRL:    w_result = A >> B[4:0];
      OP_SRA:    w_result = $signed(A) >>> B[4:0];
      OP_SLTU:   w_set = (A < B);
      OP_SLT:    w_set = ($signed(A) < $signed(B));
      OP_SGE:    w_set = ($signed(A) >= $signed(B));
      OP_SEQ:    w_set = (A == B);
      OP_SNE:    w_set = (A != B);
      OP_ADDF: begin
        w_result = w_fadd_result;
        w_ovf    = w_fadd_ovf;
      end
      OP_CVTITF: w_result = w_itf_result;
      OP_CVTFTI: begin
        w_result = w_fti_result;
        w_ovf    = w_fti_ovf;
      end
      default:   w_result = 32'd0;
    endcase
    if (w_set) w_result = 32'd1;
  end

  // Output register; reset wins over the op sampled on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 32'd0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_set    <= 1'b0;
    end else begin
      r_result <= w_result;
      r_carry  <= w_carry;
      r_ovf    <= w_ovf;
      r_zero   <= (w_result == 32'd0);
      r_set    <= w_set;
    end
  end

  assign Result   = r_result;
  assign Carryout = r_carry;
  assign Overflow = r_ovf;
  assign Zero     = r_zero;
  assign Set      = r_set;

endmodule

// File: tb/tb_alu_32bit.sv
// tb/tb_alu_32bit.sv - randomized and directed self-checking bench for alu_32bit
module tb_alu_32bit;
  import alu_32bit_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        s;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Op;
  logic [31:0] Result;
  logic        Carryout;
  logic        Overflow;
  logic        Zero;
  logic        Set;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_32bit dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .Op       (Op),
    .Result   (Result),
    .Carryout (Carryout),
    .Overflow (Overflow),
    .Zero     (Zero),
    .Set      (Set)
  );

  // Float add from the arithmetic rules: align to the larger exponent by truncation, add, renormalise.
  function automatic logic [32:0] m_addf(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, ex;
    longint va, vb, sum, mag;
    logic   sg;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b1, 32'h7FC0_0000};
    va = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]});
    vb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]});
    ex = (ea > eb) ? ea : eb;
    va = (ex - ea > 40) ? 64'sd0 : (va >> (ex - ea));
    vb = (ex - eb > 40) ? 64'sd0 : (vb >> (ex - eb));
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    sum = va + vb;
    if (sum == 0) return 33'd0;
    sg  = (sum < 0);
    mag = sg ? -sum : sum;
    while (mag >= 64'sd16777216) begin mag = mag / 2; ex++; end
    while (mag < 64'sd8388608) begin mag = mag * 2; ex--; end
    if (ex >= 255) return {1'b1, sg, 8'hFF, 23'd0};
    if (ex <= 0) return 33'd0;
    return {1'b0, sg, 8'(ex), 23'(mag)};
  endfunction

  function automatic logic [31:0] m_itf(input logic [31:0] a);
    longint mag;
    int     p;
    if (a == 32'd0) return 32'd0;
    mag = longint'($signed(a));
    if (mag < 0) mag = -mag;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    return {a[31], 8'(127 + p), 23'((p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p)))};
  endfunction

  function automatic logic [32:0] m_fti(input logic [31:0] a);
    int          e, ue;
    longint      mag;
    logic [31:0] sat;
    sat = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e   = int'(a[30:23]);
    if (e == 255) return {1'b1, sat};
    if (e < 127) return 33'd0;
    ue = e - 127;
    if (ue >= 31) begin
      if (a[31] && ue == 31 && a[22:0] == 23'd0) return {1'b0, 32'h8000_0000};
      return {1'b1, sat};
    end
    mag = longint'({1'b1, a[22:0]}) * (64'sd1 << ue) / (64'sd1 << 23);
    if (a[31]) mag = -mag;
    return {1'b0, 32'(mag)};
  endfunction

  function automatic outs_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    outs_t           e;
    longint unsigned us;
    longint          sd;
    logic [32:0]     fr;
    e = '0;
    case (op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_ADD: begin
        us    = {32'd0, a} + {32'd0, b};
        sd    = longint'($signed(a)) + longint'($signed(b));
        e.res = us[31:0];
        e.c   = us[32];
        e.o   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      OP_SUB: begin
        us    = {32'd0, a} + {32'd0, ~b} + 64'd1;
        sd    = longint'($signed(a)) - longint'($signed(b));
        e.res = us[31:0];
        e.c   = us[32];
        e.o   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      OP_SLL: e.res = a << b[4:0];
      OP_SRL: e.res = a >> b[4:0];
      OP_SRA: e.res = 32'($signed(a) >>> b[4:0]);
      OP_SLTU: e.s = (a < b);
      OP_SLT:  e.s = ($signed(a) < $signed(b));
      OP_SGE:  e.s = ($signed(a) >= $signed(b));
      OP_SEQ:  e.s = (a == b);
      OP_SNE:  e.s = (a != b);
      OP_ADDF: begin fr = m_addf(a, b); e.res = fr[31:0]; e.o = fr[32]; end
      OP_CVTITF: e.res = m_itf(a);
      OP_CVTFTI: begin fr = m_fti(a); e.res = fr[31:0]; e.o = fr[32]; end
      default: e.res = 32'd0;
    endcase
    if (e.s) e.res = 32'd1;
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got res=%h c/o/z/s=%b expected res=%h c/o/z/s=%b",
               name, act[35:4], act[3:0], want[35:4], want[3:0]);
    end
  endtask

  // Every-cycle scoreboard: expectation captured on the sampling edge, compared half a cycle later.
  outs_t exp_q;
  logic  have_exp = 1'b0;
  always @(posedge clk) begin
    exp_q    <= reset ? outs_t'('0) : model(A, B, Op);
    have_exp <= 1'b1;
  end
  always @(negedge clk) begin
    if (have_exp) check($sformatf("cycle@%0t", $time), {Result, Carryout, Overflow, Zero, Set}, exp_q);
  end

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic [31:0] er,
                          input logic ec, input logic eo, input logic ez, input logic es);
    logic [35:0] want;
    want = {er, ec, eo, ez, es};
    check({"model_", name}, model(a, b, op), want);
    @(posedge clk); #1;
    A = a; B = b; Op = op;
    @(posedge clk);
    @(negedge clk);
    check(name, {Result, Carryout, Overflow, Zero, Set}, want);
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 9))
      0: f = {f[31], 31'd0};
      1: f[30:23] = 8'hFF;
      2: f[30:23] = 8'h00;
      3: f[30:23] = 8'hFE;
      4: f[30:23] = 8'(127 + $urandom_range(25, 35));
      default: f[30:23] = 8'($urandom_range(100, 160));
    endcase
    return f;
  endfunction

  function automatic logic [31:0] rand_int();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'($signed($urandom_range(0, 64)) - 32);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    A = 32'd0; B = 32'd0; Op = OP_ADD;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_state", {Result, Carryout, Overflow, Zero, Set}, 36'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    directed("sub_5_4",      32'd5,        32'd4,        OP_SUB,  32'd1,        1, 0, 0, 0);
    directed("sub_m5_m70",   32'hFFFF_FFFB, 32'hFFFF_FFBA, OP_SUB, 32'd65,      1, 0, 0, 0);
    directed("add_m45_m20",  32'hFFFF_FFD3, 32'hFFFF_FFEC, OP_ADD, 32'hFFFF_FFBF, 1, 0, 0, 0);
    directed("add_ovf",      32'd100,      32'h7FFF_FFFD, OP_ADD,  32'h8000_0061, 0, 1, 0, 0);
    directed("add_m1_1",     32'hFFFF_FFFF, 32'd1,       OP_ADD,  32'd0,        1, 0, 1, 0);
    directed("sll",          32'd1023,     32'd2,        OP_SLL,  32'd4092,     0, 0, 0, 0);
    directed("srl",          32'd1023,     32'd2,        OP_SRL,  32'd255,      0, 0, 0, 0);
    directed("sra",          32'h8000_0000, 32'd4,       OP_SRA,  32'hF800_0000, 0, 0, 0, 0);
    directed("slt",          32'hFFFF_FFF1, 32'hFFFF_FFF9, OP_SLT, 32'd1,       0, 0, 0, 1);
    directed("sltu",         32'd1024,     32'd2133,     OP_SLTU, 32'd1,        0, 0, 0, 1);
    directed("sge",          32'd3024,     32'd2133,     OP_SGE,  32'd1,        0, 0, 0, 1);
    directed("seq",          32'd7,        32'd7,        OP_SEQ,  32'd1,        0, 0, 0, 1);
    directed("sne_false",    32'd7,        32'd7,        OP_SNE,  32'd0,        0, 0, 1, 0);
    directed("or",           32'd1,        32'd4,        OP_OR,   32'd5,        0, 0, 0, 0);
    directed("and",          32'd7,        32'd5,        OP_AND,  32'd5,        0, 0, 0, 0);
    directed("xor",          32'd13,       32'd7,        OP_XOR,  32'd10,       0, 0, 0, 0);
    directed("reserved",     32'd13,       32'd7,        5'b10000, 32'd0,       0, 0, 1, 0);
    directed("addf",         32'h4170_0000, 32'h4370_0000, OP_ADDF, 32'h437F_0000, 0, 0, 0, 0);
    directed("addf_cancel",  32'h3F80_0000, 32'hBF80_0000, OP_ADDF, 32'd0,      0, 0, 1, 0);
    directed("addf_inf",     32'h7F7F_FFFF, 32'h7F7F_FFFF, OP_ADDF, 32'h7F80_0000, 0, 1, 0, 0);
    directed("addf_nan",     32'h7F80_0000, 32'h3F80_0000, OP_ADDF, 32'h7FC0_0000, 0, 1, 0, 0);
    directed("cvtitf_15",    32'd15,       32'd0,        OP_CVTITF, 32'h4170_0000, 0, 0, 0, 0);
    directed("cvtitf_min",   32'h8000_0000, 32'd9,       OP_CVTITF, 32'hCF00_0000, 0, 0, 0, 0);
    directed("cvtitf_0",     32'd0,        32'd5,        OP_CVTITF, 32'd0,      0, 0, 1, 0);
    directed("cvtfti_big",   32'h4E7F_FFFF, 32'd0,       OP_CVTFTI, 32'h3FFF_FFC0, 0, 0, 0, 0);
    directed("cvtfti_1024",  32'h4480_0000, 32'd0,       OP_CVTFTI, 32'h0000_0400, 0, 0, 0, 0);
    directed("cvtfti_sat",   32'h4F80_0000, 32'd0,       OP_CVTFTI, 32'h7FFF_FFFF, 0, 1, 0, 0);
    directed("cvtfti_min",   32'hCF00_0000, 32'd0,       OP_CVTFTI, 32'h8000_0000, 0, 0, 0, 0);

    // Reset mid-stream with a live op, then the first post-reset result one cycle later.
    @(posedge clk); #1;
    A = 32'd2; B = 32'd3; Op = OP_ADD; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("reset_mid", {Result, Carryout, Overflow, Zero, Set}, 36'd0);
    @(posedge clk); #1;
    reset = 1'b0; A = 32'd10; B = 32'd20; Op = OP_ADD;
    @(negedge clk);
    check("post_reset_hold", {Result, Carryout, Overflow, Zero, Set}, 36'd0);
    @(posedge clk); @(negedge clk);
    check("post_reset_first", {Result, Carryout, Overflow, Zero, Set}, {32'd30, 4'b0000});

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      Op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) Op = ($urandom_range(0, 1) == 0) ? OP_ADDF : OP_CVTFTI;
      if (Op == OP_ADDF || Op == OP_CVTFTI) begin
        A = rand_float();
        B = ($urandom_range(0, 7) == 0) ? {~A[31], A[30:0]} : rand_float();
      end else begin
        A = rand_int();
        B = ($urandom_range(0, 7) == 0) ? A : rand_int();
      end
    end
    @(posedge clk); @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
